// File: rtl/alu_pkg.sv
// Shared ALU package: default sizes and operand helpers.
// Used by the negate-path arbiter and its datapath.
package alu_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_NREQ  = 4;
  localparam int MAXW      = 64;

  // True when op (zero-extended) is 1 followed by zeros at width w.
  function automatic logic is_min_neg(
    input logic [MAXW-1:0] op,
    input int              w
  );
    logic [MAXW-1:0] m;
    m = MAXW'(1) << (w - 1);
    return op == m;
  endfunction

endpackage

// File: rtl/twos_com.sv
// Combinational two's-complement negation.
// Result wraps modulo 2^WIDTH, so the most-negative value maps to itself.
module twos_com
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_op,
  output logic [WIDTH-1:0] o_res
);

  assign o_res = ~i_op + WIDTH'(1);

endmodule

// File: rtl/neg_arbiter.sv
// Round-robin arbiter sharing one negator among NREQ requesters.
// One registered result stage, one result per cycle.
module neg_arbiter
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_ovf,
  output logic                  res_zero,
  output logic                  busy
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IDW-1:0]   r_id;
  logic             r_ovf;
  logic             r_zero;
  logic [IDW-1:0]   r_ptr;

  logic             w_can_load;
  logic             w_found;
  logic             w_xfer;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_nxt;
  logic [WIDTH-1:0] w_op;
  logic [WIDTH-1:0] w_neg;

  assign w_can_load = !r_valid || res_ready;
  assign w_xfer     = w_can_load && w_found;

  // Scan upward from the pointer; first valid requester wins.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Operand mux and one-hot grant for the winner.
  always_comb begin
    w_op      = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_op         = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = w_xfer;
      end
    end
  end

  assign w_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

  twos_com #(
    .WIDTH (WIDTH)
  ) u_neg (
    .i_op  (w_op),
    .o_res (w_neg)
  );

  // Result stage: load on transfer, empty on pop, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_neg;
      r_id    <= w_win;
      r_ovf   <= is_min_neg(MAXW'(w_op), WIDTH);
      r_zero  <= (w_op == '0);
      r_ptr   <= w_nxt;
    end else if (res_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign res_ovf   = r_ovf;
  assign res_zero  = r_zero;
  assign busy      = r_valid;

endmodule

// File: tb/tb_neg_arbiter.sv
// Self-checking bench for neg_arbiter.
// Directed test-plan steps followed by randomized traffic.
module tb_neg_arbiter;

  localparam int W   = 5;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic           res_ovf;
  logic           res_zero;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  // Reference model of the result register and rotation pointer.
  bit m_valid;
  int m_data;
  int m_id;
  bit m_ovf;
  bit m_zero;
  int m_ptr;

  always #5 clk = ~clk;

  neg_arbiter #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf),
    .res_zero  (res_zero),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int a0, input int a1,
                                          input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0;
    m_ovf = 0; m_zero = 0; m_ptr = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".valid"}, 32'(res_valid), 32'(m_valid));
    chk({tag, ".busy"},  32'(busy),      32'(m_valid));
    chk({tag, ".data"},  32'(res_data),  32'(m_data));
    chk({tag, ".id"},    32'(res_id),    32'(m_id));
    chk({tag, ".ovf"},   32'(res_ovf),   32'(m_ovf));
    chk({tag, ".zero"},  32'(res_zero),  32'(m_zero));
  endtask

  // One clock: drive on negedge, check grant, then check the register.
  task automatic cyc(input string tag, input logic [N-1:0] v,
                     input logic [N*W-1:0] d, input logic rr);
    bit can;
    int g;
    int op;
    logic [N-1:0] er;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    res_ready = rr;
    #1;
    can = !m_valid || rr;
    g   = pick(v);
    er  = (can && g >= 0) ? N'(1) << g : '0;
    chk({tag, ".ready"}, 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
    if (can && g >= 0) begin
      op      = int'(d[g*W +: W]);
      m_data  = ((1 << W) - op) % (1 << W);
      m_id    = g;
      m_ovf   = (op == (1 << (W - 1)));
      m_zero  = (op == 0);
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (rr) begin
      m_valid = 0;
    end
    chk_out(tag);
  endtask

  initial begin
    logic [N*W-1:0] rd;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    model_reset();
    #2;
    chk_out("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cyc("single", 4'b0001, pack(6, 0, 0, 0), 1'b1);
    chk("single.const", 32'(res_data), 32'(5'b11010));

    cyc("zero", 4'b0100, pack(0, 0, 0, 0), 1'b1);
    chk("zero.const", {res_data, res_zero}, {5'b00000, 1'b1});
    cyc("minneg", 4'b0100, pack(0, 0, 16, 0), 1'b1);
    chk("minneg.const", {res_data, res_ovf}, {5'b10000, 1'b1});
    cyc("ones", 4'b0100, pack(0, 0, 31, 0), 1'b1);
    chk("ones.const", {res_data, res_ovf, res_zero}, {5'b00001, 2'b00});

    cyc("drain", 4'b0000, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cyc("rr", 4'b1111, pack(1, 2, 3, 4), 1'b1);
      chk("rr.seq", 32'(res_id), 32'(i % 4));
    end

    cyc("bp_load", 4'b1111, pack(5, 6, 7, 8), 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("bp_stall", 4'b1111, pack(9, 10, 11, 12), 1'b0);
    cyc("bp_release", 4'b1111, pack(9, 10, 11, 12), 1'b1);
    chk("bp_release.valid", 32'(res_valid), 32'(1));

    cyc("ph_drain", 4'b0000, '0, 1'b1);
    cyc("ph_g1", 4'b0010, pack(0, 3, 0, 0), 1'b1);
    chk("ph_g1.id", 32'(res_id), 32'(1));
    cyc("ph_idle", 4'b0000, '0, 1'b1);
    cyc("ph_idle", 4'b0000, '0, 1'b1);
    cyc("ph_wrap", 4'b0011, pack(2, 3, 0, 0), 1'b1);
    chk("ph_wrap.id", 32'(res_id), 32'(0));

    cyc("rst_fill", 4'b1000, pack(0, 0, 0, 7), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_out("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rst_after", 4'b0101, pack(4, 0, 9, 0), 1'b1);
    chk("rst_after.id", 32'(res_id), 32'(0));

    for (int i = 0; i < 300; i++) begin
      rd = {$urandom, $urandom};
      cyc("rand", N'($urandom), rd, 1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
